// File: rtl/shift_conv_window_engine.sv
// KxK sliding-window convolver with power-of-two (shift + sign) weights.
// Weights load serially (K*K beats, row-major). Pixel columns then stream in,
// and each accepted column that completes a window produces one saturated
// result two pipeline stages later.
//
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   w_start                      begin (or restart) a weight load
//   w_valid/w_data/w_ready       weight beats, w_data = {sign, shift}
//   in_valid/in_col/in_last      pixel column stream, in_col[r*DW +: DW] = row r
//   in_ready                     column accepted when in_valid && in_ready
//   out_valid/out_data/out_ready signed saturated result stream
//   relu_en                      clamp negative results to zero (stage 2)
//   busy                         high while loading weights or draining
module shift_conv_window_engine #(
    parameter int unsigned K  = 5,
    parameter int unsigned DW = 8,
    parameter int unsigned SW = 3,
    parameter int unsigned OW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            w_start,
    input  logic            w_valid,
    input  logic [SW:0]     w_data,
    output logic            w_ready,
    input  logic            in_valid,
    input  logic [K*DW-1:0] in_col,
    input  logic            in_last,
    output logic            in_ready,
    output logic            out_valid,
    output logic [OW-1:0]   out_data,
    input  logic            out_ready,
    input  logic            relu_en,
    output logic            busy
);

    localparam int unsigned NT = K * K;
    localparam int unsigned PW = DW + 2**SW;
    localparam int unsigned AW = PW + 1 + $clog2(NT);
    localparam int unsigned BW = $clog2(NT);
    localparam int unsigned CW = $clog2(K + 1);
    localparam logic signed [AW-1:0] SAT_MAX = AW'(2**(OW-1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                 state, state_nx;
    logic [BW-1:0]          beat_idx;
    logic [SW-1:0]          w_shift [NT];
    logic                   w_sign  [NT];
    logic [DW-1:0]          win     [K][K];
    logic [DW-1:0]          win_nx  [K][K];
    logic [CW-1:0]          col_cnt;
    logic [CW-1:0]          cnt_inc;
    logic signed [AW-1:0]   row_sum    [K];
    logic signed [AW-1:0]   row_sum_nx [K];
    logic signed [AW-1:0]   sat_c;
    logic                   s1_valid;
    logic                   advance;
    logic                   col_acc;
    logic                   launch;
    logic                   w_acc;
    logic                   last_beat;

    // Handshake decode; a w_start in RUN blocks the column that cycle.
    assign advance   = !out_valid || out_ready;
    assign w_ready   = (state == LOAD);
    assign busy      = (state == LOAD) || (state == DRAIN);
    assign in_ready  = (state == RUN) && advance && !w_start;
    assign col_acc   = in_valid && in_ready;
    assign w_acc     = w_valid && w_ready;
    assign last_beat = w_acc && !w_start && (beat_idx == BW'(NT - 1));
    assign cnt_inc   = (col_cnt == CW'(K)) ? col_cnt : col_cnt + CW'(1);
    assign launch    = col_acc && (cnt_inc == CW'(K));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (w_start) state_nx = LOAD;
            LOAD:    if (last_beat) state_nx = RUN;
            RUN:     if (w_start) state_nx = DRAIN;
            DRAIN:   if (!s1_valid && !out_valid) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // Weight storage; beat i lands on tap (i/K, i%K) = flat index i.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_idx <= '0;
            for (int i = 0; i < NT; i++) begin
                w_shift[i] <= '0;
                w_sign[i]  <= 1'b0;
            end
        end else if (state == LOAD) begin
            if (w_start) begin
                beat_idx <= '0;
            end else if (w_acc) begin
                w_shift[beat_idx] <= w_data[SW-1:0];
                w_sign[beat_idx]  <= w_data[SW];
                beat_idx          <= last_beat ? '0 : beat_idx + BW'(1);
            end
        end else begin
            beat_idx <= '0;
        end
    end

    // Window after the incoming column shifts in (column 0 is the oldest).
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win_nx[r][c] = win[r][c + 1];
            win_nx[r][K - 1] = in_col[r*DW +: DW];
        end
    end

    // Stage-1 row sums over the post-shift window, full precision.
    always_comb begin : row_sum_comb
        logic signed [AW-1:0] acc;
        logic [PW-1:0]        mag;
        for (int r = 0; r < K; r++) begin
            acc = '0;
            for (int c = 0; c < K; c++) begin
                mag = PW'(win_nx[r][c]) << w_shift[r*K + c];
                acc = w_sign[r*K + c] ? acc - AW'(mag) : acc + AW'(mag);
            end
            row_sum_nx[r] = acc;
        end
    end

    // Stage-2 total, optional ReLU, then saturation to OW bits.
    always_comb begin : stage2_comb
        logic signed [AW-1:0] acc;
        acc = '0;
        for (int r = 0; r < K; r++) acc = acc + row_sum[r];
        if (relu_en && (acc < 0)) acc = '0;
        if (acc > SAT_MAX)      sat_c = SAT_MAX;
        else if (acc < SAT_MIN) sat_c = SAT_MIN;
        else                    sat_c = acc;
    end

    // Window, column counter and the two pipeline stages; both stages hold
    // together whenever the output is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt   <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int r = 0; r < K; r++) begin
                row_sum[r] <= '0;
                for (int c = 0; c < K; c++) win[r][c] <= '0;
            end
        end else begin
            if (col_acc) begin
                win     <= win_nx;
                col_cnt <= in_last ? '0 : cnt_inc;
            end
            if (advance) begin
                s1_valid  <= launch;
                out_valid <= s1_valid;
                if (launch)   row_sum  <= row_sum_nx;
                if (s1_valid) out_data <= OW'(sat_c);
            end
        end
    end

endmodule

// File: tb/tb_shift_conv_window_engine.sv
// Self-checking bench for shift_conv_window_engine: directed scenarios plus
// randomized streams checked against a plain-arithmetic convolution model.
module tb_shift_conv_window_engine;

    localparam int unsigned K  = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned OW = 16;
    localparam int unsigned NT = K * K;
    localparam longint SMAX = (longint'(1) << (OW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (OW - 1));

    logic            clk = 1'b0;
    logic            reset;
    logic            w_start, w_valid, w_ready;
    logic [SW:0]     w_data;
    logic            in_valid, in_last, in_ready;
    logic [K*DW-1:0] in_col;
    logic            out_valid, out_ready, relu_en, busy;
    logic [OW-1:0]   out_data;

    int checks = 0;
    int errors = 0;

    int m_win [K][K];
    int m_cnt;
    int m_shift [NT];
    int m_sign  [NT];
    bit m_relu;
    int exp_q[$];
    int got_q[$];

    shift_conv_window_engine #(.K(K), .DW(DW), .SW(SW), .OW(OW)) dut (
        .clk(clk), .reset(reset),
        .w_start(w_start), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .in_valid(in_valid), .in_col(in_col), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .relu_en(relu_en), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge values are the ones
    // the next posedge sees.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) got_q.push_back(int'($signed(out_data)));
    end

    // ---------------- reference model ----------------
    function automatic int model_result();
        longint s = 0;
        longint p;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) begin
                p = longint'(m_win[r][c]) * (longint'(1) << m_shift[r*K + c]);
                if (m_sign[r*K + c] != 0) s = s - p;
                else                      s = s + p;
            end
        if (m_relu && s < 0) s = 0;
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return int'(s);
    endfunction

    function automatic void model_push(input logic [K*DW-1:0] col, input bit last);
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) m_win[r][c] = m_win[r][c + 1];
            m_win[r][K - 1] = int'(col[r*DW +: DW]);
        end
        if (m_cnt < K) m_cnt++;
        if (m_cnt == K) exp_q.push_back(model_result());
        if (last) m_cnt = 0;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) m_win[r][c] = 0;
        for (int i = 0; i < NT; i++) begin
            m_shift[i] = 0;
            m_sign[i]  = 0;
        end
        m_cnt  = 0;
        m_relu = 0;
        exp_q.delete();
    endfunction

    function automatic logic [K*DW-1:0] rand_col(input int maxv);
        logic [K*DW-1:0] c;
        for (int r = 0; r < K; r++) c[r*DW +: DW] = DW'($urandom_range(0, maxv));
        return c;
    endfunction

    function automatic logic [K*DW-1:0] flat_col(input int v);
        logic [K*DW-1:0] c;
        for (int r = 0; r < K; r++) c[r*DW +: DW] = DW'(v);
        return c;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; w_start = 1'b0; w_valid = 1'b0; w_data = '0;
        in_valid = 1'b0; in_col = '0; in_last = 1'b0; out_ready = 1'b1; relu_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        got_q.delete();
    endtask

    task automatic rand_weights();
        for (int i = 0; i < NT; i++) begin
            m_shift[i] = int'($urandom_range(0, 7));
            m_sign[i]  = int'($urandom_range(0, 1));
        end
    endtask

    task automatic load_beats();
        int n = 0;
        while (!w_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!w_ready) begin
            errors++;
            $display("FAIL load_wait: w_ready=%0b required 1 after %0d cycles", w_ready, n);
        end
        for (int i = 0; i < NT; i++) begin
            w_valid = 1'b1;
            w_data  = {1'(m_sign[i]), SW'(m_shift[i])};
            @(posedge clk);
            #1;
        end
        w_valid = 1'b0;
    endtask

    task automatic load_weights();
        w_start = 1'b1;
        @(posedge clk);
        #1;
        w_start = 1'b0;
        load_beats();
    endtask

    task automatic send_col(input logic [K*DW-1:0] col, input bit last, input bit rnd);
        int n = 0;
        bit ok = 1'b0;
        in_valid = 1'b1; in_col = col; in_last = last;
        while (!ok && n < 200) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (ok) model_push(col, last);
        else begin
            checks++;
            errors++;
            $display("FAIL send_col: column not accepted within %0d cycles", n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b need 0", out_valid); end
        if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %0d need 0", out_data); end
        if (w_ready !== 1'b0)   begin errors++; $display("FAIL reset_w_ready: got %0b need 0", w_ready); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %0b need 0", in_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b need 0", busy); end
    endtask

    task automatic test_unit_weights();
        logic          ov [1:8];
        logic [OW-1:0] od [1:8];
        do_reset();
        load_weights();
        in_valid = 1'b1; in_col = flat_col(1); in_last = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            ov[i] = out_valid;
            od[i] = out_data;
            if (i == 6) in_valid = 1'b0;
        end
        checks += 6;
        if (ov[5] !== 1'b0)        begin errors++; $display("FAIL unit_latency_early: out_valid=%0b need 0", ov[5]); end
        if (ov[6] !== 1'b1)        begin errors++; $display("FAIL unit_latency: out_valid=%0b need 1", ov[6]); end
        if (od[6] !== OW'(25))     begin errors++; $display("FAIL unit_sum: got %0d need 25", od[6]); end
        if (ov[7] !== 1'b1)        begin errors++; $display("FAIL unit_b2b_valid: out_valid=%0b need 1", ov[7]); end
        if (od[7] !== OW'(25))     begin errors++; $display("FAIL unit_b2b_sum: got %0d need 25", od[7]); end
        if (got_q.size() != 2)     begin errors++; $display("FAIL unit_count: got %0d results need 2", got_q.size()); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < NT; i++) m_shift[i] = 7;
        load_weights();
        for (int i = 0; i < K; i++) send_col(flat_col(255), 1'b0, 1'b0);
        idle(4);
        checks++;
        if (got_q.size() != 1 || got_q[0] != 32767) begin
            errors++;
            $display("FAIL sat_pos: got %0d results first %0d need 32767", got_q.size(), got_q.size() > 0 ? got_q[0] : 0);
        end
        do_reset();
        for (int i = 0; i < NT; i++) begin m_shift[i] = 7; m_sign[i] = 1; end
        load_weights();
        for (int i = 0; i < K; i++) send_col(flat_col(255), 1'b0, 1'b0);
        idle(4);
        relu_en = 1'b1; m_relu = 1'b1;
        send_col(flat_col(255), 1'b0, 1'b0);
        idle(4);
        checks += 3;
        if (got_q.size() != 2) begin errors++; $display("FAIL sat_neg_count: got %0d need 2", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] != -32768) begin errors++; $display("FAIL sat_neg: got %0d need -32768", got_q[0]); end
        if (got_q.size() > 1 && got_q[1] != 0) begin errors++; $display("FAIL sat_relu: got %0d need 0", got_q[1]); end
    endtask

    task automatic test_centre_tap();
        logic [K*DW-1:0] col;
        do_reset();
        for (int i = 0; i < NT; i++) begin m_shift[i] = 0; m_sign[i] = 1; end
        m_shift[2*K + 2] = 3; m_sign[2*K + 2] = 0;
        load_weights();
        for (int c = 0; c < K; c++) begin
            col = flat_col(1);
            if (c == 2) col[2*DW +: DW] = DW'(10);
            send_col(col, 1'b0, 1'b0);
        end
        idle(4);
        checks++;
        if (got_q.size() != 1 || got_q[0] != 56) begin
            errors++;
            $display("FAIL centre_tap: got %0d results first %0d need 56", got_q.size(), got_q.size() > 0 ? got_q[0] : 0);
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] held;
        do_reset();
        rand_weights();
        load_weights();
        out_ready = 1'b0;
        for (int i = 0; i < K + 1; i++) send_col(rand_col(255), 1'b0, 1'b0);
        held = out_data;
        in_valid = 1'b1; in_col = rand_col(255);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %0b need 1", out_valid); end
            if (out_data !== held)  begin errors++; $display("FAIL stall_data: got %0d need %0d", out_data, held); end
            if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready: got %0b need 0", in_ready); end
        end
        in_valid = 1'b0;
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL stall_leak: got %0d results need 0", got_q.size()); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_col(rand_col(255), 1'b0, 1'b0);
        idle(5);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL stall_result[%0d]: got %0d need %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_in_last();
        do_reset();
        rand_weights();
        load_weights();
        for (int i = 1; i <= 12; i++) send_col(rand_col(30), (i == 7), 1'b0);
        idle(5);
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL last_count: got %0d results need 4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL last_result[%0d]: got %0d need %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_drain_reload();
        logic [K*DW-1:0] col;
        int n = 0;
        do_reset();
        rand_weights();
        load_weights();
        for (int i = 0; i < K + 1; i++) begin
            col = rand_col(60);
            in_valid = 1'b1; in_col = col; in_last = 1'b0;
            model_push(col, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        w_start  = 1'b1;
        @(posedge clk);
        #1;
        w_start = 1'b0;
        checks += 3;
        if (busy !== 1'b1)      begin errors++; $display("FAIL drain_busy: got %0b need 1", busy); end
        if (w_ready !== 1'b0)   begin errors++; $display("FAIL drain_w_ready: got %0b need 0", w_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_inflight: got %0b need 1", out_valid); end
        while (!w_ready && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            checks++;
            if (w_ready && (out_valid || got_q.size() < 2)) begin
                errors++;
                $display("FAIL drain_early_load: w_ready=1 with out_valid=%0b results=%0d", out_valid, got_q.size());
            end
        end
        checks += 2;
        if (w_ready !== 1'b1) begin errors++; $display("FAIL drain_timeout: w_ready=%0b need 1", w_ready); end
        if (got_q.size() != 2) begin errors++; $display("FAIL drain_count: got %0d results need 2", got_q.size()); end
        rand_weights();
        load_beats();
        send_col(rand_col(60), 1'b0, 1'b0);
        idle(4);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reload_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL reload_result[%0d]: got %0d need %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load_weights();
        in_valid = 1'b1; in_col = flat_col(3); in_last = 1'b0;
        repeat (K + 1) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        got_q.delete();
        @(posedge clk);
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b need 0", out_valid); end
        if (out_data !== '0)    begin errors++; $display("FAIL midrst_out_data: got %0d need 0", out_data); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL midrst_in_ready: got %0b need 0", in_ready); end
        if (w_ready !== 1'b0)   begin errors++; $display("FAIL midrst_w_ready: got %0b need 0", w_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %0b need 0", busy); end
        reset = 1'b0;
        idle(5);
        checks += 2;
        if (got_q.size() != 0) begin errors++; $display("FAIL midrst_flush: got %0d results need 0", got_q.size()); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_idle: in_ready=%0b need 0", in_ready); end
        model_reset();
    endtask

    task automatic test_random();
        int maxv;
        bit relu;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            rand_weights();
            relu = 1'($urandom_range(0, 1));
            relu_en = relu; m_relu = relu;
            load_weights();
            maxv = (round == 0) ? 3 : (round == 1) ? 40 : 255;
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                send_col(rand_col(maxv), ($urandom_range(0, 9) == 0), 1'b1);
            end
            out_ready = 1'b1;
            idle(6);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_count round %0d: got %0d need %0d", round, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] != exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_result round %0d [%0d]: got %0d need %0d", round, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unit_weights();
        test_saturation();
        test_centre_tap();
        test_backpressure();
        test_in_last();
        test_drain_reload();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
